// File: rtl/ttt_game_ctrl.sv
// Tic-tac-toe game-state controller: cursor, placement, turn and win/draw tracking.
// Optional turn timeout is enabled by defining TURN_TIMEOUT_EN.
module ttt_game_ctrl #(
  parameter logic FIRST_SIGN = 1'b0
`ifdef TURN_TIMEOUT_EN
  ,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd500_000_000
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_select,
  input  logic        btn_restart,
  output logic [17:0] data,
  output logic        is_ended,
  output logic [3:0]  cursor,
  output logic        turn,
  output logic [1:0]  winner
);

  typedef enum logic [1:0] {
    PLAY,
    CHECK,
    ENDED
  } state_e;

  // Cell masks of the 3 rows, 3 columns and 2 diagonals.
  localparam logic [8:0] LINES [8] = '{
    9'b000_000_111, 9'b000_111_000, 9'b111_000_000,
    9'b001_001_001, 9'b010_010_010, 9'b100_100_100,
    9'b100_010_001, 9'b001_010_100
  };

  state_e     state_q, state_d;
  logic [8:0] chk_q, chk_d;
  logic [8:0] sgn_q, sgn_d;
  logic [3:0] cursor_q, cursor_d;
  logic       turn_q, turn_d;
  logic [1:0] winner_q, winner_d;
  logic       ended_q, ended_d;
  logic       win_x, win_o;
  logic [3:0] cur_inc, cur_dec;
  logic       placed;

`ifdef TURN_TIMEOUT_EN
  logic [31:0] cnt_q, cnt_d;
`endif

  always_comb begin
    win_x = 1'b0;
    win_o = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if ((chk_q & LINES[i]) == LINES[i]) begin
        if ((sgn_q & LINES[i]) == LINES[i]) win_o = 1'b1;
        if ((sgn_q & LINES[i]) == 9'd0)     win_x = 1'b1;
      end
    end
  end

  assign cur_inc = (cursor_q == 4'd8) ? 4'd0 : cursor_q + 4'd1;
  assign cur_dec = (cursor_q == 4'd0) ? 4'd8 : cursor_q - 4'd1;

  always_comb begin
    state_d  = state_q;
    chk_d    = chk_q;
    sgn_d    = sgn_q;
    cursor_d = cursor_q;
    turn_d   = turn_q;
    winner_d = winner_q;
    ended_d  = ended_q;
    placed   = 1'b0;
`ifdef TURN_TIMEOUT_EN
    cnt_d    = cnt_q;
`endif
    if (btn_restart) begin
      state_d  = PLAY;
      chk_d    = '0;
      sgn_d    = '0;
      cursor_d = '0;
      turn_d   = FIRST_SIGN;
      winner_d = 2'b00;
      ended_d  = 1'b0;
`ifdef TURN_TIMEOUT_EN
      cnt_d    = '0;
`endif
    end else begin
      unique case (state_q)
        PLAY: begin
          if (btn_select) begin
            if (!chk_q[cursor_q]) begin
              chk_d[cursor_q] = 1'b1;
              sgn_d[cursor_q] = turn_q;
              placed          = 1'b1;
              state_d         = CHECK;
            end
          end else if (btn_left ^ btn_right) begin
            cursor_d = btn_right ? cur_inc : cur_dec;
          end
`ifdef TURN_TIMEOUT_EN
          if (placed) begin
            cnt_d = '0;
          end else if (cnt_q == TIMEOUT_CYCLES - 32'd1) begin
            cnt_d  = '0;
            turn_d = ~turn_q;
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
`endif
        end
        CHECK: begin
          if (win_o || win_x) begin
            winner_d = win_o ? 2'b10 : 2'b01;
            ended_d  = 1'b1;
            state_d  = ENDED;
          end else if (&chk_q) begin
            winner_d = 2'b11;
            ended_d  = 1'b1;
            state_d  = ENDED;
          end else begin
            turn_d  = ~turn_q;
            state_d = PLAY;
`ifdef TURN_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end
        end
        ENDED: ;
        default: state_d = PLAY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= PLAY;
      chk_q    <= '0;
      sgn_q    <= '0;
      cursor_q <= '0;
      turn_q   <= FIRST_SIGN;
      winner_q <= 2'b00;
      ended_q  <= 1'b0;
`ifdef TURN_TIMEOUT_EN
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      chk_q    <= chk_d;
      sgn_q    <= sgn_d;
      cursor_q <= cursor_d;
      turn_q   <= turn_d;
      winner_q <= winner_d;
      ended_q  <= ended_d;
`ifdef TURN_TIMEOUT_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

  assign data     = {chk_q, sgn_q};
  assign is_ended = ended_q;
  assign cursor   = cursor_q;
  assign turn     = turn_q;
  assign winner   = winner_q;

endmodule

// File: tb/tb_ttt_game_ctrl.sv
// Bench for ttt_game_ctrl: directed scenarios plus random pulses vs. a board model.
// Build with TURN_TIMEOUT_EN defined to exercise the timeout with TIMEOUT_CYCLES = 10.
module tb_ttt_game_ctrl;

  localparam int TO = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        btn_left = 1'b0;
  logic        btn_right = 1'b0;
  logic        btn_select = 1'b0;
  logic        btn_restart = 1'b0;
  logic [17:0] data;
  logic        is_ended;
  logic [3:0]  cursor;
  logic        turn;
  logic [1:0]  winner;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: board cells 0 empty, 1 cross, 2 nought; phase 0 play, 1 check, 2 over.
  int m_board [9];
  int m_cur, m_turn, m_win, m_phase, m_cnt;
  int lines [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                       '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

`ifdef TURN_TIMEOUT_EN
  ttt_game_ctrl #(.FIRST_SIGN(1'b0), .TIMEOUT_CYCLES(TO)) dut (
`else
  ttt_game_ctrl #(.FIRST_SIGN(1'b0)) dut (
`endif
    .clk(clk), .rst(rst),
    .btn_left(btn_left), .btn_right(btn_right),
    .btn_select(btn_select), .btn_restart(btn_restart),
    .data(data), .is_ended(is_ended), .cursor(cursor),
    .turn(turn), .winner(winner)
  );

  always #5 clk = ~clk;

  task automatic model_step(input logic l, r, s, rs, rr);
    int w;
    int full;
    if (rr || rs) begin
      for (int i = 0; i < 9; i++) m_board[i] = 0;
      m_cur = 0; m_turn = 0; m_win = 0; m_phase = 0; m_cnt = 0;
    end else if (m_phase == 0) begin
      int placed = 0;
      if (s) begin
        if (m_board[m_cur] == 0) begin
          m_board[m_cur] = m_turn + 1;
          m_phase = 1;
          placed = 1;
        end
      end else if (l && !r) begin
        m_cur = (m_cur + 8) % 9;
      end else if (r && !l) begin
        m_cur = (m_cur + 1) % 9;
      end
`ifdef TURN_TIMEOUT_EN
      if (placed != 0) m_cnt = 0;
      else if (m_cnt == TO - 1) begin
        m_turn = 1 - m_turn;
        m_cnt = 0;
      end else m_cnt++;
`endif
    end else if (m_phase == 1) begin
      w = 0;
      full = 1;
      for (int k = 0; k < 8; k++) begin
        int a = m_board[lines[k][0]];
        if (a != 0 && a == m_board[lines[k][1]] && a == m_board[lines[k][2]])
          w = a;
      end
      for (int i = 0; i < 9; i++) if (m_board[i] == 0) full = 0;
      if (w != 0) begin
        m_win = w; m_phase = 2;
      end else if (full != 0) begin
        m_win = 3; m_phase = 2;
      end else begin
        m_turn = 1 - m_turn; m_phase = 0; m_cnt = 0;
      end
    end
  endtask

  task automatic drive(input logic l, r, s, rs);
    btn_left = l; btn_right = r; btn_select = s; btn_restart = rs;
    @(posedge clk);
    model_step(l, r, s, rs, rst);
    #1;
    btn_left = 0; btn_right = 0; btn_select = 0; btn_restart = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 0, 0, 0);
    rst = 1'b0;
  endtask

  task automatic goto_cell(input int from, input int to);
    int fwd = (to - from + 9) % 9;
    if (fwd <= 4) repeat (fwd) drive(0, 1, 0, 0);
    else repeat (9 - fwd) drive(1, 0, 0, 0);
  endtask

  task automatic place(input int from, input int to);
    goto_cell(from, to);
    drive(0, 0, 1, 0);
    drive(0, 0, 0, 0);
  endtask

  task automatic test_reset();
    do_reset();
    drive(0, 0, 0, 0);
    n_cmp++;
    if ({data, cursor, turn, winner, is_ended} !== 26'd0) begin
      n_bad++;
      $display("FAIL reset: data=%h cur=%0d turn=%b win=%b end=%b want all 0",
               data, cursor, turn, winner, is_ended);
    end
  endtask

  task automatic test_cursor();
    do_reset();
    drive(1, 0, 0, 0);
    n_cmp++;
    if (cursor !== 4'd8) begin
      n_bad++; $display("FAIL wrap_left: cursor=%0d want 8", cursor);
    end
    drive(0, 1, 0, 0);
    n_cmp++;
    if (cursor !== 4'd0) begin
      n_bad++; $display("FAIL wrap_right: cursor=%0d want 0", cursor);
    end
    drive(0, 1, 0, 0);
    drive(1, 1, 0, 0);
    n_cmp++;
    if (cursor !== 4'd1) begin
      n_bad++; $display("FAIL both_lr: cursor=%0d want 1", cursor);
    end
  endtask

  task automatic test_win();
    do_reset();
    place(0, 0); place(0, 3); place(3, 1); place(1, 4);
    goto_cell(4, 2);
    drive(0, 0, 1, 0);
    n_cmp++;
    if (data !== {9'b000011111, 9'b000011000} || is_ended !== 1'b0) begin
      n_bad++; $display("FAIL win_data: data=%h end=%b want %h 0",
                        data, is_ended, {9'b000011111, 9'b000011000});
    end
    drive(0, 0, 0, 0);
    n_cmp++;
    if (winner !== 2'b01 || is_ended !== 1'b1 || turn !== 1'b0) begin
      n_bad++; $display("FAIL win_flag: win=%b end=%b turn=%b want 01 1 0",
                        winner, is_ended, turn);
    end
    drive(0, 1, 1, 0);
    drive(1, 0, 0, 0);
    n_cmp++;
    if (cursor !== 4'd2 || data !== {9'b000011111, 9'b000011000}) begin
      n_bad++; $display("FAIL ended_ignore: cur=%0d data=%h want 2 %h",
                        cursor, data, {9'b000011111, 9'b000011000});
    end
  endtask

  task automatic test_occupied();
    do_reset();
    place(0, 4);
    drive(0, 0, 1, 0);
    drive(0, 0, 0, 0);
    n_cmp++;
    if (data !== 18'h02000 || turn !== 1'b1) begin
      n_bad++; $display("FAIL occupied: data=%h turn=%b want 02000 1", data, turn);
    end
    place(4, 5);
    n_cmp++;
    if (data !== 18'h06020 || turn !== 1'b0) begin
      n_bad++; $display("FAIL after_occ: data=%h turn=%b want 06020 0", data, turn);
    end
  endtask

  task automatic test_draw();
    do_reset();
    place(0, 0); place(0, 1); place(1, 2); place(2, 4); place(4, 3);
    place(3, 5); place(5, 7); place(7, 6); place(6, 8);
    n_cmp++;
    if (winner !== 2'b11 || is_ended !== 1'b1 || data !== {9'h1FF, 9'h072}) begin
      n_bad++; $display("FAIL draw: win=%b end=%b data=%h want 11 1 %h",
                        winner, is_ended, data, {9'h1FF, 9'h072});
    end
  endtask

  task automatic test_restart_ended();
    drive(0, 0, 1, 1);
    n_cmp++;
    if ({data, cursor, turn, winner, is_ended} !== 26'd0) begin
      n_bad++;
      $display("FAIL restart: data=%h cur=%0d turn=%b win=%b end=%b want all 0",
               data, cursor, turn, winner, is_ended);
    end
  endtask

`ifdef TURN_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    repeat (TO - 1) drive(0, 0, 0, 0);
    n_cmp++;
    if (turn !== 1'b0) begin
      n_bad++; $display("FAIL timeout_early: turn=%b want 0", turn);
    end
    drive(0, 0, 0, 0);
    n_cmp++;
    if (turn !== 1'b1 || data !== 18'h0) begin
      n_bad++; $display("FAIL timeout: turn=%b data=%h want 1 0", turn, data);
    end
  endtask
`endif

  task automatic test_random();
    logic [17:0] exp_d;
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 2) == 0, $urandom_range(0, 63) == 0);
      rst = 1'b0;
      exp_d = '0;
      for (int i = 0; i < 9; i++) begin
        if (m_board[i] != 0) exp_d[9+i] = 1'b1;
        if (m_board[i] == 2) exp_d[i] = 1'b1;
      end
      n_cmp++;
      if (data !== exp_d || cursor !== 4'(m_cur) || turn !== 1'(m_turn) ||
          winner !== 2'(m_win) || is_ended !== (m_phase == 2)) begin
        n_bad++;
        $display("FAIL random c=%0d: data=%h cur=%0d turn=%b win=%b end=%b want %h %0d %0d %0d %0d",
                 c, data, cursor, turn, winner, is_ended,
                 exp_d, m_cur, m_turn, m_win, m_phase == 2);
      end
    end
  endtask

  initial begin
    test_reset();
    test_cursor();
    test_win();
    test_occupied();
    test_draw();
    test_restart_ended();
`ifdef TURN_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
